// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M mult/div issue controller:
// FSM states, 4-bit op encodings and default hold latencies.
package mdu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_LAT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // [3] set means "not an M op"; [2:0] is funct3
    localparam logic [3:0] OP_MUL    = 4'b0000;
    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_DIV    = 4'b0100;
    localparam logic [3:0] OP_DIVU   = 4'b0101;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;
    localparam logic [3:0] OP_NONE   = 4'b1000;

    function automatic logic is_m_op(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the combinational Mult_Div_Unit. Latches one
// M-extension op, holds it on the unit's inputs for a fixed window while
// stalling the pipeline, then captures the result for writeback.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   ex_valid_i, ex_op_i      execute-stage instruction and its op code
//   ex_rs1_i, ex_rs2_i       operands
//   ex_rd_i                  destination register
//   flush_i                  pipeline kill, aborts the op in flight
//   stall_o, busy_o          upstream hold / controller not idle
//   mdu_op_o, mdu_a_o/b_o    held inputs of Mult_Div_Unit
//   mdu_result_i             Mult_Div_Unit result
//   wb_valid_o, wb_rd_o,     one-cycle writeback of the completed op
//   wb_data_o
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic [3:0]      ex_op_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic [3:0]      mdu_op_o,
    output logic [XLEN-1:0] mdu_a_o,
    output logic [XLEN-1:0] mdu_b_o,
    input  logic [XLEN-1:0] mdu_result_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX) + 1;

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [3:0]      op_q,    op_d;
    logic [XLEN-1:0] a_q,     a_d;
    logic [XLEN-1:0] b_q,     b_d;
    logic [4:0]      rd_q,    rd_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_dat_q, wb_dat_d;

    logic            accept;
    logic            div_by_zero;

    assign accept = (state_q == IDLE) && ex_valid_i
                 && is_m_op(ex_op_i) && !flush_i;

    // A zero divisor needs no iteration time in the unit, so the
    // result is taken after a single hold cycle.
    assign div_by_zero = is_div_op(ex_op_i) && (ex_rs2_i == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        wb_rd_d  = wb_rd_q;
        wb_dat_d = wb_dat_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = ex_op_i;
                    a_d     = ex_rs1_i;
                    b_d     = ex_rs2_i;
                    rd_d    = ex_rd_i;
                    state_d = WAIT;
                    if (!is_div_op(ex_op_i)) begin
                        cnt_d = MUL_CNT;
                    end else if (div_by_zero) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = DIV_CNT;
                    end
                end
            end
            WAIT: begin
                // flush beats completion in the same cycle
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    op_d    = OP_NONE;
                end else if (cnt_q == '0) begin
                    wb_dat_d = mdu_result_i;
                    wb_rd_d  = rd_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // operands stay put; only the op returns to idle code
                state_d = IDLE;
                op_d    = OP_NONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                op_d    = OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            wb_rd_q  <= '0;
            wb_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            wb_rd_q  <= wb_rd_d;
            wb_dat_q <= wb_dat_d;
        end
    end

    assign stall_o    = accept || ((state_q == WAIT) && !flush_i);
    assign busy_o     = (state_q != IDLE);
    assign wb_valid_o = (state_q == DONE) && !flush_i;

    assign mdu_op_o   = op_q;
    assign mdu_a_o    = a_q;
    assign mdu_b_o    = b_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_dat_q;

endmodule
